// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulus counter and its prescaler.
package mod_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int unsigned DEFAULT_WIDTH    = 8;
  localparam int unsigned DEFAULT_PRESCALE = 1;

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits one step every PRESCALE enabled cycles.
module counter_prescaler
  import mod_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;

  // With PRESCALE=1 the phase sits at LAST (=0) forever, so step follows en.
  assign step = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Programmable-modulus up/down counter with wrap/saturate, load, prescaler and tc/ovf flags.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned          WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned          PRESCALE  = DEFAULT_PRESCALE,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] max_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q;
  logic             ovf_q;
  logic             step;
  logic             at_top, at_bot, boundary;

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .en  (en),
    .step(step)
  );

  // ">=" so a count left above a shrunken max_val is treated as a boundary.
  assign at_top   = (count_q >= max_val);
  assign at_bot   = (count_q == '0);
  assign boundary = step && ((up_dn == DIR_UP) ? at_top : at_bot);

  always_comb begin
    count_d = count_q;
    if (up_dn == DIR_UP) begin
      if (at_top) begin
        count_d = (sat_mode == MODE_SAT) ? max_val : '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else begin
      if (at_bot) begin
        count_d = (sat_mode == MODE_SAT) ? '0 : max_val;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (load) begin
        count_q <= load_val;
        tc_q    <= 1'b0;
      end else if (step) begin
        count_q <= count_d;
        tc_q    <= boundary;
      end else begin
        tc_q    <= 1'b0;
      end
      // Set beats clear when both happen in the same cycle.
      ovf_q <= (ovf_q && !clr_ovf) || (boundary && !load);
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: PRESCALE=1 instance for function, PRESCALE=3 for prescaling.
module tb_mod_counter;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic         up_dn;
  logic         sat_mode;
  logic [W-1:0] max_val;
  logic         clr_ovf;

  logic [W-1:0] count0, count1;
  logic         tc0, tc1, ovf0, ovf1, zero0, zero1;

  int n_checks = 0;
  int n_fails  = 0;

  mod_counter #(
    .WIDTH    (W),
    .PRESCALE (1),
    .RESET_VAL(8'd0)
  ) dut0 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .up_dn   (up_dn),
    .sat_mode(sat_mode),
    .max_val (max_val),
    .clr_ovf (clr_ovf),
    .count   (count0),
    .tc      (tc0),
    .ovf     (ovf0),
    .zero    (zero0)
  );

  mod_counter #(
    .WIDTH    (W),
    .PRESCALE (3),
    .RESET_VAL(8'd0)
  ) dut1 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .up_dn   (up_dn),
    .sat_mode(sat_mode),
    .max_val (max_val),
    .clr_ovf (clr_ovf),
    .count   (count1),
    .tc      (tc1),
    .ovf     (ovf1),
    .zero    (zero1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; up_dn = 1'b1;
    sat_mode = 1'b0; max_val = 8'd255; clr_ovf = 1'b0;
    tick();
    check("rst_count", count0, 0);
    check("rst_tc", tc0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_zero", zero0, 1);
    rst = 1'b0;

    // Compatibility wrap 0..255
    en = 1'b1;
    repeat (255) tick();
    check("compat_255", count0, 255);
    check("compat_255_tc", tc0, 0);
    check("compat_255_zero", zero0, 0);
    tick();
    check("compat_wrap", count0, 0);
    check("compat_wrap_tc", tc0, 1);
    check("compat_wrap_ovf", ovf0, 1);
    en = 1'b0;
    tick();
    check("compat_tc_1cyc", tc0, 0);
    check("compat_hold", count0, 0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf_a", ovf0, 0);

    // Saturate down
    max_val = 8'd10; sat_mode = 1'b1; up_dn = 1'b0;
    do_load(8'd2);
    check("satdn_load", count0, 2);
    en = 1'b1;
    tick();
    check("satdn_1", count0, 1);
    check("satdn_1_tc", tc0, 0);
    tick();
    check("satdn_0", count0, 0);
    check("satdn_0_tc", tc0, 0);
    check("satdn_0_ovf", ovf0, 0);
    tick();
    check("satdn_hold", count0, 0);
    check("satdn_hold_tc", tc0, 1);
    check("satdn_ovf", ovf0, 1);
    en = 1'b0;
    tick();
    check("satdn_tc_end", tc0, 0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("satdn_clr", ovf0, 0);

    // Load priority over step
    up_dn = 1'b1; sat_mode = 1'b0; max_val = 8'd100;
    do_load(8'd5);
    check("ld_5", count0, 5);
    en = 1'b1;
    do_load(8'd200);
    check("ld_200", count0, 200);
    check("ld_200_tc", tc0, 0);
    tick();
    check("ld_wrap", count0, 0);
    check("ld_wrap_tc", tc0, 1);
    do_load(8'd200);
    check("ld_again", count0, 200);
    check("ld_clears_tc", tc0, 0);
    up_dn = 1'b0;
    tick();
    check("ld_down", count0, 199);
    check("ld_down_tc", tc0, 0);
    en = 1'b0;

    // Reset mid-run with a boundary pending
    up_dn = 1'b1; max_val = 8'd57;
    do_load(8'd57);
    check("rm_57", count0, 57);
    en = 1'b1; rst = 1'b1; load = 1'b1; load_val = 8'd99; clr_ovf = 1'b0;
    tick();
    check("rm_count", count0, 0);
    check("rm_tc", tc0, 0);
    check("rm_ovf", ovf0, 0);
    rst = 1'b0; load = 1'b0; en = 1'b0;

    // Set wins over clear
    max_val = 8'd10;
    do_load(8'd10);
    en = 1'b1; clr_ovf = 1'b1;
    tick();
    check("race_count", count0, 0);
    check("race_tc", tc0, 1);
    check("race_ovf", ovf0, 1);
    en = 1'b0; clr_ovf = 1'b0;

    // Shrink max_val below count
    max_val = 8'd255;
    do_load(8'd50);
    max_val = 8'd20; en = 1'b1;
    tick();
    check("shrink_wrap", count0, 0);
    check("shrink_tc", tc0, 1);
    en = 1'b0;
    do_load(8'd50);
    sat_mode = 1'b1; en = 1'b1;
    tick();
    check("shrink_sat", count0, 20);
    check("shrink_sat_tc", tc0, 1);
    tick();
    check("sat_repeat", count0, 20);
    check("sat_repeat_tc", tc0, 1);
    en = 1'b0; sat_mode = 1'b0;

    // Prescaler, PRESCALE=3
    rst = 1'b1; max_val = 8'd255; up_dn = 1'b1;
    tick();
    rst = 1'b0;
    check("ps_rst", count1, 0);
    check("ps_rst_ovf", ovf1, 0);
    check("ps_rst_zero", zero1, 1);
    en = 1'b1;
    tick(); tick();
    check("ps_2", count1, 0);
    tick();
    check("ps_3", count1, 1);
    check("ps_3_tc", tc1, 0);
    tick(); tick();
    check("ps_5", count1, 1);
    tick();
    check("ps_6", count1, 2);
    tick();
    en = 1'b0;
    tick(); tick();
    en = 1'b1;
    tick();
    check("ps_gap_late", count1, 2);
    tick();
    check("ps_gap_step", count1, 3);
    tick(); tick();
    do_load(8'd10);
    check("ps_load", count1, 10);
    tick(); tick();
    check("ps_phase_clr", count1, 10);
    tick();
    check("ps_phase_step", count1, 11);
    en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised successor to the team's fixed 8-bit free-running wrap counter.
- Adds the following over the 8-bit counter:
  - programmable modulus
  - up/down direction
  - wrap or saturate mode
  - parallel load
  - count enable with a built-in prescaler
  - terminal-count pulse and sticky overflow flag
- Used as the general timing/event counter in the lab designs, driven directly by the board clock domain.

Parameters:
- WIDTH, 8, counter width in bits (>= 2).
- PRESCALE, 1, number of enabled cycles per count step (>= 1; 1 = step every enabled cycle).
- RESET_VAL, 0, value loaded into count on reset (WIDTH bits).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; feeds the prescaler.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value written to count on load.
- up_dn  input  1  direction: 1 = up, 0 = down.
- sat_mode  input  1  boundary mode: 1 = saturate, 0 = wrap.
- max_val  input  WIDTH  modulus top; legal count range is 0..max_val.
- clr_ovf  input  1  clears the sticky overflow flag.
- count  output  WIDTH  registered counter value.
- tc  output  1  registered terminal-count pulse, exactly one cycle wide.
- ovf  output  1  sticky flag: a boundary step has occurred since the last clear/reset.
- zero  output  1  combinational (count == 0), decoded from the count register.

Behaviour:
- Reset, on a clk edge with rst=1:
  - count = RESET_VAL, tc = 0, ovf = 0, prescaler = 0.
  - rst overrides every other input, including mid-step or mid-load.
- Priority per edge: rst > load > step > hold.
- load=1:
  - count = load_val (no clamping to max_val); prescaler cleared; tc = 0.
  - en is ignored that cycle.
- Prescaler (sub-module):
  - Counts enabled cycles 0..PRESCALE-1 and emits step on the cycle its count is PRESCALE-1, then returns to 0.
  - en=0 freezes it. With PRESCALE=1, step = en.
- Up step (up_dn=1):
  - count < max_val: count+1.
  - count >= max_val is a boundary step:
    - wrap: count = 0.
    - saturate: count holds at max_val. If count > max_val, count is set to max_val.
- Down step (up_dn=0):
  - count > 0: count-1, even when count > max_val.
  - count == 0 is a boundary step:
    - wrap: count = max_val.
    - saturate: count holds at 0.
- Boundary step effects:
  - tc = 1 for the following cycle only. Repeated boundary steps in saturate mode pulse tc on every step.
  - ovf set to 1.
- Non-boundary step or hold: tc = 0.
- clr_ovf:
  - Clears ovf on the next edge.
  - If a boundary step occurs in the same cycle, set wins (ovf stays 1).
- Changing max_val, up_dn or sat_mode takes effect on the next step; there is no pipelining.
- Latency: count reflects a step or load one clock after the triggering cycle. tc is aligned with the count update.
- Arithmetic: all WIDTH-bit unsigned; the +1 and -1 carries are never visible at the output.
- Compatibility: with max_val = all-ones, up_dn=1, sat_mode=0, en=1, PRESCALE=1 and load=0, the block behaves as the 8-bit counter (0..255 wrap), apart from the synchronous reset.

Decomposition:
- Shared package constants:
  - DIR_UP = 1'b1, DIR_DOWN = 1'b0.
  - MODE_WRAP = 1'b0, MODE_SAT = 1'b1.
  - Default WIDTH/PRESCALE values.
- One sub-module, counter_prescaler:
  - Parameter PRESCALE.
  - Ports clk, rst, clr (= load), en, step.
  - Internal width of $clog2(PRESCALE) with a minimum of 1.
- Boundary decode and next-count mux stay in mod_counter.

Test Plan:
- Compatibility wrap, WIDTH=8, max_val=255, up, wrap, en=1: from rst, after 255 steps count=255; on step 256 count=0, tc=1 for one cycle, ovf=1.
- Saturate down, max_val=10:
  - load_val=2, then 3 steps down: count 1, 0, 0; tc pulses on the third step; ovf=1.
  - Then clr_ovf with no step: ovf=0.
- Load priority: count=5, en=1, load=1, load_val=200, max_val=100 -> count=200 next edge, no tc. Next up step with wrap -> count=0, tc=1. Next down step with count=200 -> count=199.
- Prescaler, PRESCALE=3:
  - en=1 continuous: count increments every 3rd cycle.
  - en dropped for 2 cycles mid-interval: the increment is delayed by exactly 2 cycles.
  - load clears the prescaler phase.
- Reset mid-run: count=57, tc pending, rst=1 for one cycle -> count=RESET_VAL, tc=0, ovf=0 next edge regardless of load/en/clr_ovf.
- Set-wins race: boundary step and clr_ovf asserted in the same cycle -> ovf=1.
- Shrink max_val: count=50, max_val changed to 20, wrap, up step -> count=0, tc=1.
